trace_delta_packer: RTL and testbench
=====================================

# trace_delta_packer

Change-record packer that watches a flat vector of per-instance status bits (INSTANCES × VARS), and emits one record per changed bit over a valid/ready stream. After reset it first emits a full initial dump, then only deltas. Bits changing faster than the consumer drains are coalesced, never lost. It sits directly downstream of the replicated per-instance signal generators and feeds the trace writer.

## Interface
- INSTANCES, 10, number of producer instances
- VARS, 10, bits per instance; N = INSTANCES*VARS, IDX_W = $clog2(N)
- FIFO_DEPTH, 8, record FIFO entries (power of two, ≥2)
- TS_W, 16, timestamp width
- clk  in  1  sole clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- sig_in  in  N  watched bits; bit i*VARS+v is instance i, var v
- rec_valid  out  1  record available
- rec_ready  in  1  consumer accepts record when rec_valid && rec_ready
- rec_index  out  IDX_W  global bit index
- rec_value  out  1  bit value being reported
- rec_dump  out  1  record belongs to the initial dump
- rec_time  out  TS_W  cycle timestamp at push
- dump_done  out  1  high once all N dump records are pushed

## Operation
- sig_q: sig_in registered every cycle; emitted: N-bit last-reported value per bit.
- FSM, states DUMP, RUN.
- DUMP: counter idx 0..N-1; each cycle FIFO not full: push {idx, sig_q[idx], dump=1, ts}, set emitted[idx]=sig_q[idx], idx++. After pushing idx N-1 → RUN, dump_done=1.
- RUN: diff = sig_q ^ emitted. If diff≠0 and FIFO not full: pick lowest set index j, push {j, sig_q[j], dump=0, ts}, emitted[j]=sig_q[j]. At most one push per cycle.
- FIFO full: no push; state, idx, emitted hold. Changes keep accumulating in diff.
- Coalescing: bit toggling twice before service yields diff=0 → no record; multiple toggles report only the final value.
- Timestamp ts: free-running TS_W counter, cleared by rst, wraps 2^TS_W−1 → 0.
- Simultaneous push and pop on full FIFO: pop only (push decision uses full from the start of the cycle).

## Timing
- Reset (rst high at posedge): FSM=DUMP, idx=0, emitted=0, sig_q=0, ts=0, FIFO empty; outputs rec_valid=0, rec_index=0, rec_value=0, rec_dump=0, rec_time=0, dump_done=0.
- rst asserted mid-dump or mid-run: all of the above, FIFO contents discarded; dump restarts from index 0.
- Latency: sig_in change sampled at edge k → sig_q at k → pushed at edge k+1 (if lowest pending and FIFO not full) → rec_valid high after edge k+1.
- FIFO is show-ahead: rec_* equal head entry while rec_valid; stable while rec_valid && !rec_ready.
- rec_valid never drops without a handshake except on rst.
- Dump with rec_ready held high: N records in N consecutive cycles, first rec_valid the cycle after reset release.
- rec_* are don't-care when rec_valid=0 but registered, zero after reset.

## Structure
- Package trace_delta_pkg: state enum {DUMP, RUN}; record struct {index, value, dump, time}; IDX_W helper function.
- One sub-module: trace_rec_fifo (synchronous show-ahead FIFO, parameterised depth and record type, full/empty flags).
- Lowest-set-bit priority encoder stays inline in trace_delta_packer.

## Test plan
- Reset, sig_in bit k = (k%2==0), rec_ready=1 → 100 dump records, indices 0..99 in order, values 1,0,1,0…, rec_dump=1, rec_time consecutive; dump_done high after the 100th push; then no records.
- After dump, flip bits 37 and 5 in one cycle → records index 5 then 37, rec_dump=0, values the new ones, 2 cycles apart from the flip to first valid.
- After dump, rec_ready=0; toggle bit 12 on/off twice and flip bit 80 once; release rec_ready → exactly one record (index 80); none for 12.
- rec_ready=0 during dump → FIFO fills with FIFO_DEPTH records (indices 0..7), rec_index stable at 0; release → remaining 92 records continue in order with no gaps or duplicates.
- rst for one cycle midway through dump at index 50 → outputs return to reset values next cycle; new dump starts at index 0.
- Hold sig_in constant for 70000 cycles with periodic single flips → rec_time wraps from 65535 to 0 correctly.

Source files
------------

// File: rtl/trace_delta_pkg.sv
// Shared types and default sizing for the trace delta packer slice.
// The record struct here is sized to the default configuration.
package trace_delta_pkg;

    typedef enum logic {
        DUMP = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_INSTANCES  = 10;
    localparam int DEF_VARS       = 10;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_TS_W       = 16;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_IDX_W = idx_w(DEF_INSTANCES * DEF_VARS);

    typedef struct packed {
        logic [DEF_IDX_W-1:0] index;
        logic                 value;
        logic                 dump;
        logic [DEF_TS_W-1:0]  ts;
    } trace_rec_t;

endpackage

// File: rtl/trace_delta_packer_if.sv
// Record stream from the packer to the trace writer, plus the dump-complete flag.
interface trace_delta_packer_if
    import trace_delta_pkg::*;
#(
    parameter int IDX_W = DEF_IDX_W,
    parameter int TS_W  = DEF_TS_W
);
    logic             rec_valid;
    logic             rec_ready;
    logic [IDX_W-1:0] rec_index;
    logic             rec_value;
    logic             rec_dump;
    logic [TS_W-1:0]  rec_time;
    logic             dump_done;

    modport master (
        output rec_valid, rec_index, rec_value, rec_dump, rec_time, dump_done,
        input  rec_ready
    );

    modport slave (
        input  rec_valid, rec_index, rec_value, rec_dump, rec_time, dump_done,
        output rec_ready
    );
endinterface

// File: rtl/trace_rec_fifo.sv
// Synchronous show-ahead FIFO; the head entry is presented while non-empty,
// and the read port reads as zero when empty so outputs are clean after reset.
module trace_rec_fifo #(
    parameter int  DEPTH = 8,
    parameter type rec_t = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  rec_t wdata,
    input  logic pop,
    output rec_t rdata,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    rec_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = empty ? rec_t'('0) : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/trace_delta_packer.sv
// Watches INSTANCES*VARS status bits and streams one record per changed bit:
// a full initial dump after reset, then lowest-index-first deltas with coalescing.
module trace_delta_packer
    import trace_delta_pkg::*;
#(
    parameter  int INSTANCES  = DEF_INSTANCES,
    parameter  int VARS       = DEF_VARS,
    parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter  int TS_W       = DEF_TS_W,
    localparam int N          = INSTANCES * VARS,
    localparam int IDX_W      = idx_w(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         sig_in,
    trace_delta_packer_if.master rec
);
    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic             value;
        logic             dump;
        logic [TS_W-1:0]  ts;
    } pkt_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [N-1:0]     sig_q;
    logic [N-1:0]     emitted, emitted_nxt;
    logic [N-1:0]     diff;
    logic [TS_W-1:0]  ts_cnt;
    logic             armed;
    logic [IDX_W-1:0] low_idx;
    logic             has_diff;
    logic             push;
    logic             full;
    logic             empty;
    pkt_t             wrec;
    pkt_t             hrec;

    assign diff = sig_q ^ emitted;

    // Scanning downward leaves the lowest set index as the final winner.
    always_comb begin
        low_idx  = '0;
        has_diff = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (diff[i]) begin
                low_idx  = IDX_W'(i);
                has_diff = 1'b1;
            end
        end
    end

    // sig_q is only meaningful one edge after reset, so nothing is pushed until armed.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        emitted_nxt = emitted;
        push        = 1'b0;
        wrec        = '{index: idx, value: sig_q[idx], dump: 1'b1, ts: ts_cnt};
        if (armed && !full) begin
            case (state)
                DUMP: begin
                    push             = 1'b1;
                    emitted_nxt[idx] = sig_q[idx];
                    if (idx == IDX_W'(N - 1)) state_nxt = RUN;
                    else                      idx_nxt   = idx + 1'b1;
                end
                RUN: begin
                    if (has_diff) begin
                        push                 = 1'b1;
                        wrec                 = '{index: low_idx, value: sig_q[low_idx],
                                                 dump: 1'b0, ts: ts_cnt};
                        emitted_nxt[low_idx] = sig_q[low_idx];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= DUMP;
            idx     <= '0;
            emitted <= '0;
            sig_q   <= '0;
            ts_cnt  <= '0;
            armed   <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            emitted <= emitted_nxt;
            sig_q   <= sig_in;
            ts_cnt  <= ts_cnt + 1'b1;
            armed   <= 1'b1;
        end
    end

    trace_rec_fifo #(
        .DEPTH (FIFO_DEPTH),
        .rec_t (pkt_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wrec),
        .pop   (rec.rec_valid && rec.rec_ready),
        .rdata (hrec),
        .full  (full),
        .empty (empty)
    );

    assign rec.rec_valid = !empty;
    assign rec.rec_index = hrec.index;
    assign rec.rec_value = hrec.value;
    assign rec.rec_dump  = hrec.dump;
    assign rec.rec_time  = hrec.ts;
    assign rec.dump_done = (state == RUN);
endmodule

// File: tb/tb_trace_delta_packer.sv
// Bench for trace_delta_packer: per-cycle queue reference model plus
// directed dump, delta, coalescing, backpressure, reset and timestamp-wrap sequences.
module tb_trace_delta_packer;
    import trace_delta_pkg::*;

    localparam int N     = 100;
    localparam int DEPTH = 8;
    localparam int IW    = DEF_IDX_W;
    localparam int TW    = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] sig_in = '0;

    trace_delta_packer_if #(.IDX_W(IW), .TS_W(TW)) rif();

    trace_delta_packer #(
        .INSTANCES  (10),
        .VARS       (10),
        .FIFO_DEPTH (DEPTH),
        .TS_W       (TW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig_in),
        .rec    (rif)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: what the packer has reported and what it has queued.
    trace_rec_t   m_q[$];
    trace_rec_t   got[$];
    logic [N-1:0] m_sig  = '0;
    logic [N-1:0] m_emit = '0;
    int           m_idx  = 0;
    bit           m_dumping = 1'b1;
    bit           m_armed   = 1'b0;
    logic [TW-1:0] m_ts = '0;

    typedef struct {
        int a;
        int b;
        int first;
        int second;
    } flip_vec_t;

    flip_vec_t tbl[5];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_edge();
        trace_rec_t r;
        bit full, pop, push;
        if (rst) begin
            m_q.delete();
            m_sig = '0; m_emit = '0; m_idx = 0;
            m_dumping = 1'b1; m_armed = 1'b0; m_ts = '0;
            return;
        end
        full = (m_q.size() == DEPTH);
        pop  = (m_q.size() > 0) && rif.rec_ready;
        push = 1'b0;
        r    = '0;
        if (m_armed && !full) begin
            if (m_dumping) begin
                r = '{index: IW'(m_idx), value: m_sig[m_idx], dump: 1'b1, ts: m_ts};
                push = 1'b1;
                m_emit[m_idx] = m_sig[m_idx];
                if (m_idx == N - 1) m_dumping = 1'b0;
                else                m_idx++;
            end else begin
                for (int j = 0; j < N; j++) begin
                    if (m_sig[j] != m_emit[j]) begin
                        r = '{index: IW'(j), value: m_sig[j], dump: 1'b0, ts: m_ts};
                        push = 1'b1;
                        m_emit[j] = m_sig[j];
                        break;
                    end
                end
            end
        end
        if (pop)  void'(m_q.pop_front());
        if (push) m_q.push_back(r);
        m_sig   = sig_in;
        m_ts    = m_ts + 1'b1;
        m_armed = 1'b1;
    endtask

    task automatic check_outputs();
        bit ev;
        ev = (m_q.size() > 0);
        cmp("rec_valid", 32'(rif.rec_valid), 32'(ev));
        if (ev) begin
            cmp("rec_index", 32'(rif.rec_index), 32'(m_q[0].index));
            cmp("rec_value", 32'(rif.rec_value), 32'(m_q[0].value));
            cmp("rec_dump",  32'(rif.rec_dump),  32'(m_q[0].dump));
            cmp("rec_time",  32'(rif.rec_time),  32'(m_q[0].ts));
        end
        cmp("dump_done", 32'(rif.dump_done), 32'(!m_dumping));
    endtask

    // One clock: log the handshake, advance the model, then sample #1 after the edge.
    task automatic step();
        trace_rec_t g;
        if (rif.rec_valid && rif.rec_ready) begin
            g = '{index: rif.rec_index, value: rif.rec_value, dump: rif.rec_dump, ts: rif.rec_time};
            got.push_back(g);
        end
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        got.delete();
    endtask

    initial begin
        bit   seen_wrap;
        int   n12;
        logic [127:0] rnd;

        tbl[0] = '{a: 37, b: 5,  first: 5,  second: 37};
        tbl[1] = '{a: 0,  b: 99, first: 0,  second: 99};
        tbl[2] = '{a: 51, b: 50, first: 50, second: 51};
        tbl[3] = '{a: 98, b: 1,  first: 1,  second: 98};
        tbl[4] = '{a: 64, b: 63, first: 63, second: 64};

        // Full dump with an alternating pattern and a free-flowing consumer.
        for (int k = 0; k < N; k++) sig_in[k] = (k % 2 == 0);
        rif.rec_ready = 1'b1;
        do_reset();
        cmp("reset_valid", 32'(rif.rec_valid), 32'd0);
        cmp("reset_done",  32'(rif.dump_done), 32'd0);
        repeat (102) step();
        cmp("dump_count", 32'(got.size()), 32'd100);
        if (got.size() > 0) cmp("dump_first_time", 32'(got[0].ts), 32'd1);
        for (int i = 0; i < got.size(); i++) begin
            cmp("dump_index", 32'(got[i].index), 32'(i));
            cmp("dump_value", 32'(got[i].value), 32'(i % 2 == 0));
            cmp("dump_flag",  32'(got[i].dump),  32'd1);
            cmp("dump_time",  32'(got[i].ts),    32'(got[0].ts + TW'(i)));
        end
        cmp("dump_done_set", 32'(rif.dump_done), 32'd1);
        repeat (10) step();
        cmp("post_dump_quiet", 32'(got.size()), 32'd100);

        // Paired flips: lowest index first, two cycles from flip to first valid.
        foreach (tbl[t]) begin
            sig_in[tbl[t].a] = ~sig_in[tbl[t].a];
            sig_in[tbl[t].b] = ~sig_in[tbl[t].b];
            got.delete();
            step();
            cmp("flip_latency_k", 32'(rif.rec_valid), 32'd0);
            step();
            cmp("flip_latency_k1", 32'(rif.rec_valid), 32'd1);
            cmp("flip_first_idx", 32'(rif.rec_index), 32'(tbl[t].first));
            repeat (4) step();
            cmp("flip_count", 32'(got.size()), 32'd2);
            if (got.size() >= 2) begin
                cmp("flip_idx0", 32'(got[0].index), 32'(tbl[t].first));
                cmp("flip_idx1", 32'(got[1].index), 32'(tbl[t].second));
                cmp("flip_val0", 32'(got[0].value), 32'(sig_in[tbl[t].first]));
                cmp("flip_val1", 32'(got[1].value), 32'(sig_in[tbl[t].second]));
                cmp("flip_dump", 32'(got[0].dump | got[1].dump), 32'd0);
            end
        end

        // Coalescing: fill the FIFO, toggle bit 12 twice, flip 80 once.
        rif.rec_ready = 1'b0;
        got.delete();
        for (int b = 90; b < 98; b++) sig_in[b] = ~sig_in[b];
        repeat (10) step();
        cmp("fill_head", 32'(rif.rec_index), 32'd90);
        repeat (4) begin
            sig_in[12] = ~sig_in[12];
            step();
            step();
        end
        sig_in[80] = ~sig_in[80];
        step();
        step();
        rif.rec_ready = 1'b1;
        repeat (15) step();
        cmp("coalesce_count", 32'(got.size()), 32'd9);
        for (int i = 0; i < 8 && i < got.size(); i++)
            cmp("coalesce_fill_idx", 32'(got[i].index), 32'(90 + i));
        if (got.size() >= 9) cmp("coalesce_idx80", 32'(got[8].index), 32'd80);
        n12 = 0;
        foreach (got[i]) if (got[i].index == IW'(12)) n12++;
        cmp("coalesce_no12", 32'(n12), 32'd0);

        // Backpressure during the dump: head holds at index 0, then the stream resumes intact.
        rif.rec_ready = 1'b0;
        do_reset();
        step();
        step();
        repeat (20) begin
            step();
            cmp("hold_valid", 32'(rif.rec_valid), 32'd1);
            cmp("hold_index", 32'(rif.rec_index), 32'd0);
        end
        rif.rec_ready = 1'b1;
        repeat (110) step();
        cmp("bp_count", 32'(got.size()), 32'd100);
        for (int i = 0; i < got.size(); i++)
            cmp("bp_index", 32'(got[i].index), 32'(i));

        // Reset midway through the dump.
        do_reset();
        repeat (52) step();
        cmp("pre_rst_index", 32'(rif.rec_index), 32'd50);
        rst = 1'b1;
        step();
        rst = 1'b0;
        cmp("rst_valid", 32'(rif.rec_valid), 32'd0);
        cmp("rst_index", 32'(rif.rec_index), 32'd0);
        cmp("rst_value", 32'(rif.rec_value), 32'd0);
        cmp("rst_dump",  32'(rif.rec_dump),  32'd0);
        cmp("rst_time",  32'(rif.rec_time),  32'd0);
        cmp("rst_done",  32'(rif.dump_done), 32'd0);
        got.delete();
        repeat (102) step();
        cmp("redump_count", 32'(got.size()), 32'd100);
        if (got.size() > 0) begin
            cmp("redump_first_idx",  32'(got[0].index), 32'd0);
            cmp("redump_first_time", 32'(got[0].ts),    32'd1);
        end

        // Randomized traffic with random backpressure against the model.
        repeat (3000) begin
            rif.rec_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                int b;
                b = $urandom_range(0, N - 1);
                sig_in[b] = ~sig_in[b];
            end
            if ($urandom_range(0, 49) == 0) begin
                rnd = {$urandom, $urandom, $urandom, $urandom};
                sig_in = sig_in ^ rnd[N-1:0];
            end
            step();
        end
        rif.rec_ready = 1'b1;
        repeat (200) step();

        // Long run with sparse flips: timestamps spaced 1000 apart across the wrap.
        got.delete();
        for (int c = 0; c < 70000; c++) begin
            if (c % 1000 == 0) sig_in[(c / 1000) % N] = ~sig_in[(c / 1000) % N];
            step();
        end
        cmp("wrap_count", 32'(got.size()), 32'd70);
        seen_wrap = 1'b0;
        for (int i = 1; i < got.size(); i++) begin
            cmp("wrap_spacing", 32'(TW'(got[i].ts - got[i-1].ts)), 32'd1000);
            if (got[i].ts < got[i-1].ts) seen_wrap = 1'b1;
        end
        cmp("wrap_seen", 32'(seen_wrap), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
